video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning), one per line:
- H_ACTIVE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: hsync asserted level; 0 means active-low.
- VS_POL, 0: vsync asserted level; 0 means active-low.
- CW, 12: width of the x and y counters.
- FCW, 16: width of frame_count.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning), one per line:
- clk, in, 1: pixel clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: advance the timing; when low, counters hold.
- resync, in, 1: one-cycle pulse that restarts the frame at (0,0).
- x, out, CW: horizontal position.
- y, out, CW: vertical position.
- vde, out, 1: video data enable (active region).
- hsync, out, 1: horizontal sync, at HS_POL polarity.
- vsync, out, 1: vertical sync, at VS_POL polarity.
- hblank, out, 1: x >= H_ACTIVE.
- vblank, out, 1: y >= V_ACTIVE.
- start_of_frame, out, 1: position is (0,0).
- end_of_line, out, 1: x == H_TOT-1.
- end_of_frame, out, 1: x == H_TOT-1 and y == V_TOT-1.
- frame_count, out, FCW: number of completed frames, wrapping.
REQ-003 One clock; reset is synchronous and active-high; ports are named clk and reset.

Function
REQ-004 H_TOT SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOT SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 Elaboration SHALL fail if H_TOT > 2**CW, if V_TOT > 2**CW, or if any of the eight timing parameters is zero.
REQ-006 x and y SHALL be registered counters, with all other outputs decoded from them in the same cycle (zero latency).
REQ-007 On an enabled cycle, x SHALL increment; when x == H_TOT-1, x SHALL wrap to 0 and y SHALL advance.
REQ-008 When y == V_TOT-1 and x wraps, y SHALL wrap to 0.
REQ-009 The asserted level of hsync SHALL be HS_POL for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise hsync SHALL be !HS_POL.
REQ-010 The asserted level of vsync SHALL be VS_POL for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; otherwise vsync SHALL be !VS_POL.
REQ-011 vde SHALL equal !hblank && !vblank && enable.
REQ-012 start_of_frame, end_of_line and end_of_frame SHALL each be gated by enable, so that a held position never repeats a pulse.
REQ-013 hsync, vsync, hblank and vblank SHALL NOT be gated by enable; they reflect the held position.
REQ-014 enable=0 SHALL hold x, y and frame_count unchanged.
REQ-015 frame_count SHALL increment by 1 (mod 2**FCW) on an enabled cycle where end_of_frame=1.
REQ-016 resync=1 SHALL set x=0 and y=0 next cycle regardless of enable, and SHALL have priority over counting.
REQ-017 resync SHALL NOT change frame_count, including when it coincides with end_of_frame.
REQ-018 reset SHALL have priority over resync and enable.

Reset
REQ-019 On reset, x, y and frame_count SHALL be 0.
REQ-020 After reset, outputs SHALL follow REQ-009..REQ-013 at (0,0): hsync=!HS_POL, vsync=!VS_POL, hblank=0, vblank=0, vde=enable, start_of_frame=enable, end_of_line=0, end_of_frame=0.
REQ-021 Reset asserted mid-frame SHALL return the block to (0,0) on the next clock with frame_count=0.

Verification
REQ-022 Bench parameters: H=8/2/3/3 (H_TOT=16), V=4/1/2/1 (V_TOT=8), HS_POL=0, VS_POL=1, FCW=4. Each bench SHALL cover the following scenarios:
- Free run, enable=1, for 3 frames: hsync=0 exactly at x=10..12; vsync=1 exactly at y=5..6; vde count = 32 per frame; frame_count=3 after 384 cycles; start_of_frame occurs every 128 cycles.
- enable held 0 for 5 cycles at (9,2): x/y stay (9,2); vde=0; hblank=1; pulses=0; counting resumes at (10,2).
- resync at (5,3): next cycle (0,0) with start_of_frame=1; frame_count unchanged.
- resync coincident with end_of_frame, and resync with enable=0: (0,0) next cycle; frame_count not incremented.
- 16 frames: frame_count wraps 15 -> 0.
- reset asserted at (7,6) with frame_count=2, resync=1 and enable=1: next cycle (0,0) and frame_count=0.

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing generator: free-running x/y raster counters with decoded
// sync, blanking, data-enable and frame/line marker outputs.
// Only x, y and frame_count are registered; every other output is a
// same-cycle decode of the current position, so there is no output latency.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 12,
  parameter int FCW      = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           resync,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           vde,
  output logic           hsync,
  output logic           vsync,
  output logic           hblank,
  output logic           vblank,
  output logic           start_of_frame,
  output logic           end_of_line,
  output logic           end_of_frame,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters must be able to reach the last position, and every region
  // must exist, otherwise the decodes below are meaningless.
  if (H_TOT > 2**CW || V_TOT > 2**CW ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("video_timing_gen: invalid timing parameters");
  end

  // Region boundaries expressed at counter width so compares are width-exact.
  localparam logic [CW-1:0] HB_START = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] VB_START = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic at_line_end;
  logic at_frame_end;
  logic in_hsync;
  logic in_vsync;

  assign at_line_end  = (x == H_LAST);
  assign at_frame_end = at_line_end && (y == V_LAST);
  assign in_hsync     = (x >= HS_START) && (x < HS_END);
  assign in_vsync     = (y >= VS_START) && (y < VS_END);

  // Sync and blanking follow the position even while held.
  assign hblank = (x >= HB_START);
  assign vblank = (y >= VB_START);
  assign hsync  = in_hsync ? HS_ON : !HS_ON;
  assign vsync  = in_vsync ? VS_ON : !VS_ON;

  // Pulses and data enable are gated so a held position never repeats them.
  assign vde            = !hblank && !vblank && enable;
  assign start_of_frame = enable && (x == '0) && (y == '0);
  assign end_of_line    = enable && at_line_end;
  assign end_of_frame   = enable && at_frame_end;

  // Raster position: reset beats resync, resync beats counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (resync) begin
      x <= '0;
      y <= '0;
    end else if (enable) begin
      if (at_line_end) begin
        x <= '0;
        if (y == V_LAST) begin
          y <= '0;
        end else begin
          y <= y + CW'(1);
        end
      end else begin
        x <= x + CW'(1);
      end
    end
  end

  // Completed-frame counter; a resync cancels the frame it interrupts.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (!resync && end_of_frame) begin
      frame_count <= frame_count + FCW'(1);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a small 16x8 raster.
// The reference keeps the raster as a linear pixel index within the frame
// and derives x, y and the decoded outputs arithmetically from it.
module tb_video_timing_gen;

  localparam int H_TOT = 16;
  localparam int V_TOT = 8;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam int W     = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic resync = 1'b0;

  always #5 clk = ~clk;

  logic [11:0] x, y;
  logic        vde, hsync, vsync, hblank, vblank;
  logic        start_of_frame, end_of_line, end_of_frame;
  logic [3:0]  frame_count;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .CW(12), .FCW(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .resync(resync),
    .x(x),
    .y(y),
    .vde(vde),
    .hsync(hsync),
    .vsync(vsync),
    .hblank(hblank),
    .vblank(vblank),
    .start_of_frame(start_of_frame),
    .end_of_line(end_of_line),
    .end_of_frame(end_of_frame),
    .frame_count(frame_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  int m_p = 0;
  int m_fc = 0;
  bit m_valid = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_p = 0;
      m_fc = 0;
      m_valid = 1;
    end else if (resync) begin
      m_p = 0;
    end else if (enable) begin
      if (m_p == F_TOT - 1) m_fc = (m_fc + 1) % 16;
      m_p = (m_p + 1) % F_TOT;
    end
    if (m_valid) exp_q.push_back({12'(m_p % H_TOT), 12'(m_p / H_TOT), 4'(m_fc)});
  end

  // ---------------- scoreboard compare ----------------
  logic [W-1:0] pos;
  int ex, ey;
  logic e_hb, e_vb, e_hs, e_vs, e_vde, e_sof, e_eol, e_eof;
  logic [35:0] e_v, a_v;

  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: no expected entry at time %0t", $time);
      end else begin
        pos   = exp_q.pop_front();
        ex    = int'(pos[27:16]);
        ey    = int'(pos[15:4]);
        e_hb  = (ex >= 8);
        e_vb  = (ey >= 4);
        e_hs  = (ex >= 10 && ex <= 12) ? 1'b0 : 1'b1;
        e_vs  = (ey >= 5 && ey <= 6) ? 1'b1 : 1'b0;
        e_vde = !e_hb && !e_vb && enable;
        e_sof = enable && ex == 0 && ey == 0;
        e_eol = enable && ex == H_TOT - 1;
        e_eof = e_eol && ey == V_TOT - 1;
        e_v = {pos[27:4], e_vde, e_hs, e_vs, e_hb, e_vb, e_sof, e_eol, e_eof, pos[3:0]};
        a_v = {x, y, vde, hsync, vsync, hblank, vblank,
               start_of_frame, end_of_line, end_of_frame, frame_count};
        if (a_v !== e_v) begin
          n_err++;
          $display("FAIL outputs at %0t: got %h, want %h", $time, a_v, e_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed scenarios ----------------
  int hs_low, hs_bad, vs_high, vs_bad, sof_cnt, sof_bad;
  int vde_f[3];

  initial begin
    step();
    step();
    // Reset state with enable low, then with enable high.
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_hblank", int'(hblank), 0);
    chk("rst_vblank", int'(vblank), 0);
    chk("rst_vde_en0", int'(vde), 0);
    chk("rst_sof_en0", int'(start_of_frame), 0);
    chk("rst_eol", int'(end_of_line), 0);
    enable = 1'b1;
    #1;
    chk("rst_vde_en1", int'(vde), 1);
    chk("rst_sof_en1", int'(start_of_frame), 1);
    reset = 1'b0;

    // Free run, three frames.
    hs_low = 0; hs_bad = 0; vs_high = 0; vs_bad = 0; sof_cnt = 0; sof_bad = 0;
    for (int f = 0; f < 3; f++) vde_f[f] = 0;
    for (int i = 0; i < 3 * F_TOT; i++) begin
      if (!hsync) begin
        hs_low++;
        if (x < 10 || x > 12) hs_bad++;
      end
      if (vsync) begin
        vs_high++;
        if (y < 5 || y > 6) vs_bad++;
      end
      if (vde) vde_f[i / F_TOT]++;
      if (start_of_frame) begin
        sof_cnt++;
        if (i % F_TOT != 0) sof_bad++;
      end
      step();
    end
    chk("run_hsync_low", hs_low, 72);
    chk("run_hsync_where", hs_bad, 0);
    chk("run_vsync_high", vs_high, 96);
    chk("run_vsync_where", vs_bad, 0);
    for (int f = 0; f < 3; f++) chk("run_vde_per_frame", vde_f[f], 32);
    chk("run_sof_count", sof_cnt, 3);
    chk("run_sof_spacing", sof_bad, 0);
    chk("run_fc", int'(frame_count), 3);
    chk("run_x", int'(x), 0);
    chk("run_y", int'(y), 0);

    // Hold at (9,2).
    advance(41);
    chk("hold_pre_x", int'(x), 9);
    chk("hold_pre_y", int'(y), 2);
    enable = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_x", int'(x), 9);
      chk("hold_y", int'(y), 2);
      chk("hold_vde", int'(vde), 0);
      chk("hold_hblank", int'(hblank), 1);
      chk("hold_pulses", int'(start_of_frame) + int'(end_of_line) + int'(end_of_frame), 0);
      step();
    end
    enable = 1'b1;
    step();
    chk("resume_x", int'(x), 10);
    chk("resume_y", int'(y), 2);
    chk("resume_hsync", int'(hsync), 0);

    // Resync at (5,3).
    advance(11);
    chk("rs_pre_x", int'(x), 5);
    chk("rs_pre_y", int'(y), 3);
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("rs_x", int'(x), 0);
    chk("rs_y", int'(y), 0);
    chk("rs_sof", int'(start_of_frame), 1);
    chk("rs_fc", int'(frame_count), 3);

    // Resync coinciding with end_of_frame.
    advance(F_TOT - 1);
    chk("rs_eof_pre", int'(end_of_frame), 1);
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("rs_eof_x", int'(x), 0);
    chk("rs_eof_y", int'(y), 0);
    chk("rs_eof_fc", int'(frame_count), 3);

    // Resync with enable low.
    advance(20);
    enable = 1'b0;
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("rs_en0_x", int'(x), 0);
    chk("rs_en0_y", int'(y), 0);
    chk("rs_en0_fc", int'(frame_count), 3);
    chk("rs_en0_sof", int'(start_of_frame), 0);
    enable = 1'b1;
    #1;
    chk("rs_en1_sof", int'(start_of_frame), 1);

    // Sixteen frames: the counter wraps 15 -> 0 along the way.
    for (int f = 1; f <= 16; f++) begin
      advance(F_TOT);
      chk("wrap_fc", int'(frame_count), (3 + f) % 16);
    end

    // Reset mid-frame at (7,6) with frame_count=2, resync and enable high.
    advance(15 * F_TOT);
    chk("mid_fc_pre", int'(frame_count), 2);
    advance(103);
    chk("mid_x_pre", int'(x), 7);
    chk("mid_y_pre", int'(y), 6);
    reset = 1'b1;
    resync = 1'b1;
    step();
    chk("mid_rst_x", int'(x), 0);
    chk("mid_rst_y", int'(y), 0);
    chk("mid_rst_fc", int'(frame_count), 0);
    reset = 1'b0;
    resync = 1'b0;
    advance(20);
    chk("post_rst_x", int'(x), 4);
    chk("post_rst_y", int'(y), 1);

    // ---------------- final report ----------------
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
